// File: rtl/ch_serializer_pkg.sv
// Shared definitions for the channel serializer: FSM encoding and channel limits.
package ch_serializer_pkg;

  localparam int NCH_MAX = 16;
  localparam int IW      = 4;   // index width, enough for NCH_MAX channels

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ch_state_e;

endpackage

// File: rtl/ch_serializer_capture.sv
// Capture bank: NCH load-enabled sample registers with a read mux by channel index.
module ch_capture
  import ch_serializer_pkg::*;
#(
  parameter int NCH = 8,
  parameter int DW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [NCH*DW-1:0] d_in,
  input  logic [IW-1:0]     idx,
  output logic [DW-1:0]     rd
);

  logic [DW-1:0] bank [NCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) bank[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NCH; i++) bank[i] <= d_in[i*DW +: DW];
    end
  end

  // Indices beyond NCH read as zero.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == IW'(i)) rd = bank[i];
    end
  end

endmodule

// File: rtl/ch_serializer.sv
// Frame serializer: on a strobe, snapshots NCH samples and streams the first n_eff out one beat at a time.
module ch_serializer
  import ch_serializer_pkg::*;
#(
  parameter int NCH = 8,
  parameter int DW  = 16,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [4:0]        numch,
  input  logic [NCH*DW-1:0] d_in,
  input  logic              ready,
  input  logic              clr_overrun,
  output logic [DW-1:0]     d_out,
  output logic [CW-1:0]     out,
  output logic              valid,
  output logic              first,
  output logic              last,
  output logic              busy,
  output logic              overrun,
  output ch_state_e         dbg_state
);

  // Handshake: a beat transfers on a rising edge where valid && ready;
  // while valid && !ready, d_out/out/first/last hold their values.

  ch_state_e       state, state_n;
  logic [IW-1:0]   index, index_n;
  logic [4:0]      n_lat, n_lat_n;
  logic [4:0]      n_eff;
  logic            load, advance, drop, xfer;
  logic [DW-1:0]   cap_rd;

  assign n_eff     = (numch > 5'(NCH)) ? 5'(NCH) : numch;
  assign xfer      = valid && ready;
  assign dbg_state = state;

  ch_capture #(.NCH(NCH), .DW(DW)) u_capture (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d_in (d_in),
    .idx  (index + 1'b1),
    .rd   (cap_rd)
  );

  always_comb begin
    state_n = state;
    index_n = index;
    n_lat_n = n_lat;
    load    = 1'b0;
    advance = 1'b0;
    drop    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe && n_eff != 5'd0) load = 1'b1;
      end
      ST_SEND: begin
        if (xfer) begin
          if (last) begin
            if (strobe && n_eff != 5'd0) load = 1'b1;
            else begin
              state_n = ST_IDLE;
              index_n = '0;
            end
          end else begin
            advance = 1'b1;
          end
        end
        // Only the final-transfer cycle may accept a new frame.
        if (strobe && !(xfer && last)) drop = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    if (load) begin
      state_n = ST_SEND;
      index_n = '0;
      n_lat_n = n_eff;
    end
    if (advance) index_n = index + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      index   <= '0;
      n_lat   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      first   <= 1'b0;
      last    <= 1'b0;
      out     <= '0;
      d_out   <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      index   <= index_n;
      n_lat   <= n_lat_n;
      valid   <= (state_n == ST_SEND);
      busy    <= (state_n == ST_SEND);
      first   <= (state_n == ST_SEND) && (index_n == '0);
      last    <= (state_n == ST_SEND) && ({1'b0, index_n} == n_lat_n - 5'd1);
      out     <= (state_n == ST_SEND) ? CW'(index_n) : '0;
      if (load)                     d_out <= d_in[DW-1:0];
      else if (advance)             d_out <= cap_rd;
      else if (state_n != ST_SEND)  d_out <= '0;
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ch_serializer.sv
// Directed bench for ch_serializer: table of frame sizes plus hand-written stall/overrun/back-to-back/reset sequences.
module tb_ch_serializer;
  import ch_serializer_pkg::*;

  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              strobe;
  logic [4:0]        numch;
  logic [NCH*DW-1:0] d_in;
  logic              ready;
  logic              clr_overrun;
  logic [DW-1:0]     d_out;
  logic [CW-1:0]     out;
  logic              valid, first, last, busy, overrun;
  ch_state_e         dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [4:0] numch;
    int         exp_n;
  } vec_t;

  vec_t vecs[7];

  ch_serializer #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .strobe      (strobe),
    .numch       (numch),
    .d_in        (d_in),
    .ready       (ready),
    .clr_overrun (clr_overrun),
    .d_out       (d_out),
    .out         (out),
    .valid       (valid),
    .first       (first),
    .last        (last),
    .busy        (busy),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_default_din();
    for (int k = 0; k < NCH; k++) d_in[k*DW +: DW] = 16'(k + 1);
  endtask

  // Beat i of an n-beat frame with the default d_in: value i+1 on channel i.
  task automatic check_beat(input string tag, input int i, input int n);
    chk({tag, ".valid"}, 32'(valid), 32'd1);
    chk({tag, ".busy"},  32'(busy),  32'd1);
    chk({tag, ".d_out"}, 32'(d_out), 32'(i + 1));
    chk({tag, ".out"},   32'(out),   32'(i));
    chk({tag, ".first"}, 32'(first), 32'(i == 0));
    chk({tag, ".last"},  32'(last),  32'(i == n - 1));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".valid"}, 32'(valid), 32'd0);
    chk({tag, ".busy"},  32'(busy),  32'd0);
  endtask

  // Driver: pulse strobe for one edge; returns at the negedge where beat 0 is visible.
  task automatic start_frame(input logic [4:0] nc);
    @(negedge clk);
    strobe = 1'b1;
    numch  = nc;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; strobe = 1'b0; numch = 5'd0; ready = 1'b1; clr_overrun = 1'b0;
    set_default_din();

    vecs[0] = '{numch: 5'd4,  exp_n: 4};
    vecs[1] = '{numch: 5'd1,  exp_n: 1};
    vecs[2] = '{numch: 5'd8,  exp_n: 8};
    vecs[3] = '{numch: 5'd12, exp_n: 8};
    vecs[4] = '{numch: 5'd0,  exp_n: 0};
    vecs[5] = '{numch: 5'd16, exp_n: 8};
    vecs[6] = '{numch: 5'd3,  exp_n: 3};

    #1;
    chk("rst.valid",   32'(valid),   32'd0);
    chk("rst.d_out",   32'(d_out),   32'd0);
    chk("rst.out",     32'(out),     32'd0);
    chk("rst.flags",   32'({first, last, busy, overrun}), 32'd0);
    chk("rst.state",   32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Table-driven frames with ready held high.
    for (int v = 0; v < 7; v++) begin
      start_frame(vecs[v].numch);
      if (vecs[v].exp_n == 0) begin
        check_idle("zero.c0");
        @(negedge clk);
        check_idle("zero.c1");
        chk("zero.overrun", 32'(overrun), 32'd0);
      end else begin
        for (int i = 0; i < vecs[v].exp_n; i++) begin
          if (i > 0) @(negedge clk);
          check_beat($sformatf("tbl%0d.b%0d", v, i), i, vecs[v].exp_n);
        end
        @(negedge clk);
        check_idle($sformatf("tbl%0d.end", v));
      end
    end

    // Downstream stall at beat 2.
    start_frame(5'd4);
    check_beat("stall.b0", 0, 4);
    @(negedge clk); check_beat("stall.b1", 1, 4);
    @(negedge clk); check_beat("stall.b2", 2, 4);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_beat($sformatf("stall.hold%0d", k), 2, 4);
    end
    ready = 1'b1;
    @(negedge clk); check_beat("stall.b3", 3, 4);
    @(negedge clk); check_idle("stall.end");

    // Dropped strobe mid-frame sets overrun; frame continues untouched.
    start_frame(5'd4);
    @(negedge clk); check_beat("ovr.b1", 1, 4);
    strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    check_beat("ovr.b2", 2, 4);
    chk("ovr.set", 32'(overrun), 32'd1);
    @(negedge clk); check_beat("ovr.b3", 3, 4);
    @(negedge clk); check_idle("ovr.end");
    chk("ovr.sticky", 32'(overrun), 32'd1);

    // Set and clear together: set wins.
    start_frame(5'd4);
    strobe = 1'b1; clr_overrun = 1'b1;
    @(negedge clk); strobe = 1'b0; clr_overrun = 1'b0;
    check_beat("setwin.b1", 1, 4);
    chk("setwin.overrun", 32'(overrun), 32'd1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check_idle("setwin.end");
    clr_overrun = 1'b1;
    @(negedge clk); clr_overrun = 1'b0;
    chk("clr.overrun", 32'(overrun), 32'd0);

    // Strobe coincident with the final transfer: back-to-back frame, no overrun.
    start_frame(5'd4);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check_beat("b2b.b3", 3, 4);
    strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    check_beat("b2b.n0", 0, 4);
    chk("b2b.overrun", 32'(overrun), 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check_beat($sformatf("b2b.n%0d", i), i, 4);
    end
    @(negedge clk); check_idle("b2b.end");

    // numch and d_in changes during a frame do not disturb it.
    start_frame(5'd4);
    numch = 5'd2;
    d_in  = {NCH{16'hAAAA}};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check_beat($sformatf("frz.b%0d", i), i, 4);
    end
    @(negedge clk); check_idle("frz.end");
    set_default_din();

    // Reset mid-frame: immediate clear, silence until next strobe.
    start_frame(5'd4);
    @(negedge clk); @(negedge clk);
    check_beat("mrst.b2", 2, 4);
    rst = 1'b1;
    #1;
    chk("mrst.valid", 32'(valid), 32'd0);
    chk("mrst.d_out", 32'(d_out), 32'd0);
    chk("mrst.out",   32'(out),   32'd0);
    chk("mrst.flags", 32'({first, last, busy, overrun}), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle($sformatf("mrst.quiet%0d", k));
    end
    start_frame(5'd2);
    check_beat("mrst.n0", 0, 2);
    @(negedge clk); check_beat("mrst.n1", 1, 2);
    @(negedge clk); check_idle("mrst.end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
